axil_addr_demux: RTL and testbench

AXIL_ADDR_DEMUX -- requirements
Module: axil_addr_demux

---
 rtl/axil_addr_demux_pkg.sv | 49 ++++
 rtl/axil_addr_demux_decode.sv | 26 ++
 rtl/axil_addr_demux.sv | 180 ++++++++++++++++++
 tb/tb_axil_addr_demux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axil_addr_demux_pkg.sv
// Shared SoC address-rule types: AXI4-Lite bundles, address windows, demux FSM states.
package axil_addr_demux_pkg;

   typedef logic [31:0] addr_t;

   typedef struct packed {
      addr_t start_addr;
      addr_t end_addr;    // exclusive
   } addr_rule_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam addr_rule_t UART_RULE       = '{start_addr: 32'h7100_0000, end_addr: 32'h7100_0030};
   localparam addr_rule_t PERIPH_TOP_RULE = '{start_addr: 32'h7000_0000, end_addr: 32'h7F00_0000};

   typedef struct packed {
      addr_t       aw_addr;
      logic [2:0]  aw_prot;
      logic        aw_valid;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
      logic        w_valid;
      logic        b_ready;
      addr_t       ar_addr;
      logic [2:0]  ar_prot;
      logic        ar_valid;
      logic        r_ready;
   } axil_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic [1:0]  b_resp;
      logic        b_valid;
      logic        ar_ready;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
      logic        r_valid;
   } axil_rsp_t;

   typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_ERRB} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} r_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axil_addr_demux_decode.sv
// Combinational address-window match; the lowest matching rule index wins.
module axil_addr_decode
   import axil_addr_demux_pkg::*;
#(
   parameter int unsigned NUM_SLV               = 2,
   parameter addr_rule_t  ADDR_RULES [NUM_SLV]  = '{UART_RULE, PERIPH_TOP_RULE},
   parameter int unsigned IDX_W                 = idx_width(NUM_SLV)
) (
   input  addr_t            addr_i,
   output logic             hit_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scanning downward lets the lowest overlapping index overwrite higher ones.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (addr_i >= ADDR_RULES[i].start_addr && addr_i < ADDR_RULES[i].end_addr) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/axil_addr_demux.sv
// AXI4-Lite 1-to-N address demux with independent write/read FSMs and decode-error tracking.
module axil_addr_demux
   import axil_addr_demux_pkg::*;
#(
   parameter int unsigned NUM_SLV              = 2,
   parameter addr_rule_t  ADDR_RULES [NUM_SLV] = '{UART_RULE, PERIPH_TOP_RULE},
   parameter int unsigned CNT_W                = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  axil_req_t        slv_req_i,
   output axil_rsp_t        slv_rsp_o,
   output axil_req_t        mst_req_o [NUM_SLV],
   input  axil_rsp_t        mst_rsp_i [NUM_SLV],
   output logic [CNT_W-1:0] dec_err_cnt_o,
   output addr_t            dec_err_addr_o
);

   localparam int unsigned IDX_W = idx_width(NUM_SLV);

   w_state_e          w_state_q, w_state_d;
   r_state_e          r_state_q, r_state_d;
   addr_t             aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
   logic [2:0]        aw_prot_q, aw_prot_d, ar_prot_q, ar_prot_d;
   logic [IDX_W-1:0]  w_idx_q, w_idx_d, r_idx_q, r_idx_d;
   logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   addr_t             err_addr_q, err_addr_d;

   logic              aw_hit, ar_hit, aw_miss, ar_miss;
   logic [IDX_W-1:0]  aw_idx, ar_idx;
   logic [CNT_W:0]    cnt_sum;

   axil_addr_decode #(.NUM_SLV(NUM_SLV), .ADDR_RULES(ADDR_RULES), .IDX_W(IDX_W)) u_aw_decode (
      .addr_i (slv_req_i.aw_addr),
      .hit_o  (aw_hit),
      .idx_o  (aw_idx)
   );

   axil_addr_decode #(.NUM_SLV(NUM_SLV), .ADDR_RULES(ADDR_RULES), .IDX_W(IDX_W)) u_ar_decode (
      .addr_i (slv_req_i.ar_addr),
      .hit_o  (ar_hit),
      .idx_o  (ar_idx)
   );

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      w_state_d = w_state_q;
      r_state_d = r_state_q;
      aw_addr_d = aw_addr_q;
      aw_prot_d = aw_prot_q;
      w_idx_d   = w_idx_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      ar_addr_d = ar_addr_q;
      ar_prot_d = ar_prot_q;
      r_idx_d   = r_idx_q;
      aw_miss   = 1'b0;
      ar_miss   = 1'b0;
      slv_rsp_o = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         mst_req_o[i]         = '0;
         mst_req_o[i].aw_addr = aw_addr_q;
         mst_req_o[i].aw_prot = aw_prot_q;
         mst_req_o[i].w_data  = slv_req_i.w_data;
         mst_req_o[i].w_strb  = slv_req_i.w_strb;
         mst_req_o[i].ar_addr = ar_addr_q;
         mst_req_o[i].ar_prot = ar_prot_q;
      end

      unique case (w_state_q)
         W_IDLE: begin
            slv_rsp_o.aw_ready = !rst_i;
            if (slv_req_i.aw_valid) begin
               aw_addr_d = slv_req_i.aw_addr;
               aw_prot_d = slv_req_i.aw_prot;
               w_idx_d   = aw_idx;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               aw_miss   = !aw_hit;
               w_state_d = aw_hit ? W_FWD : W_ERR;
            end
         end
         W_FWD: begin
            mst_req_o[w_idx_q].aw_valid = !aw_done_q;
            mst_req_o[w_idx_q].w_valid  = slv_req_i.w_valid && !w_done_q;
            slv_rsp_o.w_ready           = mst_rsp_i[w_idx_q].w_ready && !w_done_q;
            aw_done_d = aw_done_q || mst_rsp_i[w_idx_q].aw_ready;
            w_done_d  = w_done_q || (slv_req_i.w_valid && mst_rsp_i[w_idx_q].w_ready);
            if (aw_done_d && w_done_d) w_state_d = W_RESP;
         end
         W_RESP: begin
            slv_rsp_o.b_valid          = mst_rsp_i[w_idx_q].b_valid;
            slv_rsp_o.b_resp           = mst_rsp_i[w_idx_q].b_resp;
            mst_req_o[w_idx_q].b_ready = slv_req_i.b_ready;
            if (mst_rsp_i[w_idx_q].b_valid && slv_req_i.b_ready) w_state_d = W_IDLE;
         end
         W_ERR: begin
            slv_rsp_o.w_ready = 1'b1;
            if (slv_req_i.w_valid) w_state_d = W_ERRB;
         end
         W_ERRB: begin
            slv_rsp_o.b_valid = 1'b1;
            slv_rsp_o.b_resp  = RESP_DECERR;
            if (slv_req_i.b_ready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase

      unique case (r_state_q)
         R_IDLE: begin
            slv_rsp_o.ar_ready = !rst_i;
            if (slv_req_i.ar_valid) begin
               ar_addr_d = slv_req_i.ar_addr;
               ar_prot_d = slv_req_i.ar_prot;
               r_idx_d   = ar_idx;
               ar_miss   = !ar_hit;
               r_state_d = ar_hit ? R_FWD : R_ERR;
            end
         end
         R_FWD: begin
            mst_req_o[r_idx_q].ar_valid = 1'b1;
            if (mst_rsp_i[r_idx_q].ar_ready) r_state_d = R_RESP;
         end
         R_RESP: begin
            slv_rsp_o.r_valid          = mst_rsp_i[r_idx_q].r_valid;
            slv_rsp_o.r_data           = mst_rsp_i[r_idx_q].r_data;
            slv_rsp_o.r_resp           = mst_rsp_i[r_idx_q].r_resp;
            mst_req_o[r_idx_q].r_ready = slv_req_i.r_ready;
            if (mst_rsp_i[r_idx_q].r_valid && slv_req_i.r_ready) r_state_d = R_IDLE;
         end
         R_ERR: begin
            slv_rsp_o.r_valid = 1'b1;
            slv_rsp_o.r_resp  = RESP_DECERR;
            if (slv_req_i.r_ready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase

      // One extra bit catches the carry; simultaneous misses add two.
      cnt_sum    = {1'b0, cnt_q} + (CNT_W + 1)'({1'b0, aw_miss} + {1'b0, ar_miss});
      cnt_d      = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      err_addr_d = aw_miss ? slv_req_i.aw_addr : (ar_miss ? slv_req_i.ar_addr : err_addr_q);
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         aw_addr_q  <= '0;
         aw_prot_q  <= '0;
         w_idx_q    <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         ar_addr_q  <= '0;
         ar_prot_q  <= '0;
         r_idx_q    <= '0;
         cnt_q      <= '0;
         err_addr_q <= '0;
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         aw_addr_q  <= aw_addr_d;
         aw_prot_q  <= aw_prot_d;
         w_idx_q    <= w_idx_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         ar_addr_q  <= ar_addr_d;
         ar_prot_q  <= ar_prot_d;
         r_idx_q    <= r_idx_d;
         cnt_q      <= cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign dec_err_cnt_o  = cnt_q;
   assign dec_err_addr_o = err_addr_q;

endmodule

// File: tb/tb_axil_addr_demux.sv
// Directed bench for axil_addr_demux: routing, decode errors, overlap/boundary windows, reset abort.
module tb_axil_addr_demux;
   import axil_addr_demux_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   axil_req_t   req;
   axil_rsp_t   rsp;
   axil_req_t   mst_req [2];
   axil_rsp_t   mst_rsp [2];
   logic [15:0] cnt;
   addr_t       eaddr;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   axil_addr_demux dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .slv_req_i      (req),
      .slv_rsp_o      (rsp),
      .mst_req_o      (mst_req),
      .mst_rsp_i      (mst_rsp),
      .dec_err_cnt_o  (cnt),
      .dec_err_addr_o (eaddr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic write_txn(input addr_t addr, input int s, input string tag);
      int o = 1 - s;
      req.aw_valid = 1'b1; req.aw_addr = addr; req.aw_prot = 3'd2;
      req.w_valid  = 1'b1; req.w_data  = addr ^ 32'h5A5A_0000; req.w_strb = 4'hF;
      req.b_ready  = 1'b1;
      #1 check({tag, "_pre_awvalid"}, mst_req[s].aw_valid, 0);
      tick();
      req.aw_valid = 1'b0;
      #1;
      check({tag, "_awvalid"}, mst_req[s].aw_valid, 1);
      check({tag, "_awaddr"}, mst_req[s].aw_addr, addr);
      check({tag, "_other_awvalid"}, mst_req[o].aw_valid, 0);
      check({tag, "_wvalid"}, mst_req[s].w_valid, 1);
      mst_rsp[s].aw_ready = 1'b1; mst_rsp[s].w_ready = 1'b1;
      #1 check({tag, "_wready"}, rsp.w_ready, 1);
      tick();
      mst_rsp[s].aw_ready = 1'b0; mst_rsp[s].w_ready = 1'b0; req.w_valid = 1'b0;
      mst_rsp[s].b_valid = 1'b1; mst_rsp[s].b_resp = RESP_OKAY;
      #1;
      check({tag, "_bvalid"}, rsp.b_valid, 1);
      check({tag, "_bresp"}, rsp.b_resp, RESP_OKAY);
      tick();
      mst_rsp[s].b_valid = 1'b0; req.b_ready = 1'b0;
      #1 check({tag, "_bvalid_done"}, rsp.b_valid, 0);
   endtask

   // s < 0 means the address is expected to miss every window.
   task automatic read_txn(input addr_t addr, input int s, input logic [31:0] data, input string tag);
      req.ar_valid = 1'b1; req.ar_addr = addr; req.r_ready = 1'b1;
      tick();
      req.ar_valid = 1'b0;
      #1;
      if (s < 0) begin
         check({tag, "_err_rvalid"}, rsp.r_valid, 1);
         check({tag, "_err_rresp"}, rsp.r_resp, RESP_DECERR);
         check({tag, "_err_rdata"}, rsp.r_data, 0);
         check({tag, "_err_arvalid"}, {mst_req[0].ar_valid, mst_req[1].ar_valid}, 0);
      end else begin
         check({tag, "_arvalid"}, mst_req[s].ar_valid, 1);
         check({tag, "_araddr"}, mst_req[s].ar_addr, addr);
         check({tag, "_other_arvalid"}, mst_req[1-s].ar_valid, 0);
         mst_rsp[s].ar_ready = 1'b1;
         tick();
         mst_rsp[s].ar_ready = 1'b0;
         mst_rsp[s].r_valid = 1'b1; mst_rsp[s].r_data = data; mst_rsp[s].r_resp = RESP_OKAY;
         #1;
         check({tag, "_rdata"}, rsp.r_data, data);
         check({tag, "_rresp"}, rsp.r_resp, RESP_OKAY);
         check({tag, "_rready"}, mst_req[s].r_ready, 1);
      end
      tick();
      if (s >= 0) mst_rsp[s].r_valid = 1'b0;
      req.r_ready = 1'b0;
   endtask

   initial begin
      req = '0; mst_rsp[0] = '0; mst_rsp[1] = '0; rst_i = 1'b1;
      tick(); tick();
      #1;
      check("rst_awready", rsp.aw_ready, 0);
      check("rst_arready", rsp.ar_ready, 0);
      check("rst_cnt", cnt, 0);
      check("rst_eaddr", eaddr, 0);
      check("rst_mst_valids", {mst_req[0].aw_valid, mst_req[0].ar_valid, mst_req[1].aw_valid, mst_req[1].ar_valid}, 0);
      rst_i = 1'b0;
      #1 check("idle_awready", rsp.aw_ready, 1);

      // Basic routed write and read.
      write_txn(32'h7100_0004, 0, "wr_uart");
      check("wr_uart_cnt", cnt, 0);
      read_txn(32'h7000_0010, 1, 32'hDEAD_BEEF, "rd_periph");

      // Write decode miss.
      tick();
      req.aw_valid = 1'b1; req.aw_addr = 32'h1000_0000; req.w_valid = 1'b1; req.w_data = 32'h0BAD_0BAD;
      tick();
      req.aw_valid = 1'b0;
      #1;
      check("wmiss_cnt", cnt, 1);
      check("wmiss_eaddr", eaddr, 32'h1000_0000);
      check("wmiss_wready", rsp.w_ready, 1);
      check("wmiss_slave_valids", {mst_req[0].aw_valid, mst_req[0].w_valid, mst_req[1].aw_valid, mst_req[1].w_valid}, 0);
      tick();
      req.w_valid = 1'b0;
      #1;
      check("wmiss_bvalid", rsp.b_valid, 1);
      check("wmiss_bresp", rsp.b_resp, RESP_DECERR);
      req.b_ready = 1'b1;
      tick();
      req.b_ready = 1'b0;
      #1 check("wmiss_idle", rsp.aw_ready, 1);

      // W leads AW by three cycles, concurrent read to slave 1, decoy B on slave 1.
      req.w_valid = 1'b1; req.w_data = 32'hA5A5_A5A5; req.w_strb = 4'h3;
      for (int k = 0; k < 3; k++) begin
         #1 check("early_w_blocked", {rsp.w_ready, mst_req[0].w_valid, mst_req[1].w_valid}, 0);
         tick();
      end
      req.aw_valid = 1'b1; req.aw_addr = 32'h7100_0010;
      req.ar_valid = 1'b1; req.ar_addr = 32'h7000_0100;
      tick();
      req.aw_valid = 1'b0; req.ar_valid = 1'b0;
      mst_rsp[0].w_ready = 1'b1; mst_rsp[1].ar_ready = 1'b1;
      mst_rsp[1].b_valid = 1'b1; mst_rsp[1].b_resp = 2'b10;
      #1;
      check("cc_routes", {mst_req[0].aw_valid, mst_req[0].ar_valid, mst_req[1].aw_valid, mst_req[1].ar_valid}, 4'b1001);
      check("cc_wvalid", {mst_req[0].w_valid, mst_req[1].w_valid}, 2'b10);
      check("cc_wdata", mst_req[0].w_data, 32'hA5A5_A5A5);
      check("cc_wready", rsp.w_ready, 1);
      check("cc_no_early_b", rsp.b_valid, 0);
      tick();
      mst_rsp[0].w_ready = 1'b0; mst_rsp[1].ar_ready = 1'b0;
      mst_rsp[0].aw_ready = 1'b1;
      mst_rsp[1].r_valid = 1'b1; mst_rsp[1].r_data = 32'h1234_5678; req.r_ready = 1'b1;
      #1;
      check("cc_aw_held", mst_req[0].aw_valid, 1);
      check("cc_w_done", {mst_req[0].w_valid, rsp.w_ready}, 0);
      check("cc_rdata", rsp.r_data, 32'h1234_5678);
      tick();
      req.w_valid = 1'b0; mst_rsp[0].aw_ready = 1'b0;
      mst_rsp[1].r_valid = 1'b0; req.r_ready = 1'b0;
      mst_rsp[0].b_valid = 1'b1; mst_rsp[0].b_resp = RESP_OKAY; req.b_ready = 1'b1;
      #1;
      check("cc_bvalid", rsp.b_valid, 1);
      check("cc_bresp", rsp.b_resp, RESP_OKAY);
      check("cc_bready_route", {mst_req[0].b_ready, mst_req[1].b_ready}, 2'b10);
      check("cc_r_done", rsp.r_valid, 0);
      tick();
      mst_rsp[0].b_valid = 1'b0; mst_rsp[1].b_valid = 1'b0; req.b_ready = 1'b0;

      // Window boundaries and overlap priority.
      read_txn(32'h7100_0030, 1, 32'hCAFE_0030, "bnd_uart_end");
      read_txn(32'h7F00_0000, -1, 32'h0, "bnd_top_end");
      check("bnd_top_cnt", cnt, 2);
      write_txn(32'h7100_0000, 0, "bnd_overlap");
      read_txn(32'h6FFF_FFFF, -1, 32'h0, "bnd_below");
      check("bnd_below_cnt", cnt, 3);
      check("bnd_below_eaddr", eaddr, 32'h6FFF_FFFF);

      // Simultaneous AW and AR misses.
      req.aw_valid = 1'b1; req.aw_addr = 32'h1000_0004;
      req.ar_valid = 1'b1; req.ar_addr = 32'h2000_0000;
      tick();
      req.aw_valid = 1'b0; req.ar_valid = 1'b0;
      #1;
      check("dual_miss_cnt", cnt, 5);
      check("dual_miss_eaddr", eaddr, 32'h1000_0004);
      req.w_valid = 1'b1; req.b_ready = 1'b1; req.r_ready = 1'b1;
      tick();
      req.w_valid = 1'b0; req.r_ready = 1'b0;
      tick();
      req.b_ready = 1'b0;
      #1 check("dual_miss_idle", {rsp.aw_ready, rsp.ar_ready}, 2'b11);

      // Reset while a forwarded AW is stalled.
      req.aw_valid = 1'b1; req.aw_addr = 32'h7100_0008;
      tick();
      req.aw_valid = 1'b0;
      #1 check("rstmid_awvalid", mst_req[0].aw_valid, 1);
      rst_i = 1'b1;
      tick();
      #1;
      check("rstmid_valids", {mst_req[0].aw_valid, mst_req[1].aw_valid, rsp.b_valid, rsp.aw_ready}, 0);
      check("rstmid_cnt", cnt, 0);
      check("rstmid_eaddr", eaddr, 0);
      rst_i = 1'b0;
      #1 check("rstmid_idle", rsp.aw_ready, 1);
      write_txn(32'h7100_0020, 0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
